// File: rtl/noc_pkg.sv
// Shared router definitions: port numbering, one-hot grant type and index helpers.
// Used by the output-port arbiters and selectors.
package noc_pkg;

   localparam int unsigned N_PORTS = 5;
   localparam int unsigned PTR_W   = 3;

   typedef logic [N_PORTS-1:0] onehot5_t;
   typedef logic [PTR_W-1:0]   port_idx_t;

   localparam port_idx_t PORT_LOCAL = 3'd0;
   localparam port_idx_t PORT_N     = 3'd1;
   localparam port_idx_t PORT_E     = 3'd2;
   localparam port_idx_t PORT_S     = 3'd3;
   localparam port_idx_t PORT_W     = 3'd4;

   typedef enum logic [0:0] {
      StIdle,
      StLocked
   } arb_state_e;

   function automatic port_idx_t onehot_to_idx(onehot5_t oh);
      port_idx_t idx = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (oh[i]) idx = port_idx_t'(i);
      end
      return idx;
   endfunction

   function automatic port_idx_t next_port(port_idx_t p);
      return (p == PORT_W) ? PORT_LOCAL : p + 3'd1;
   endfunction

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
// master: the arbiter (drives grants); slave: the requesting side.
interface output_port_arbiter_if #(
   parameter int unsigned N_PORTS = 5,
   parameter int unsigned IDX_W   = 3
);

   logic [N_PORTS-1:0] req;
   logic [N_PORTS-1:0] tail;
   logic               out_ready;
   logic [N_PORTS-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               busy;

   modport master (
      input  req,
      input  tail,
      input  out_ready,
      output grant,
      output grant_idx,
      output busy
   );

   modport slave (
      output req,
      output tail,
      output out_ready,
      input  grant,
      input  grant_idx,
      input  busy
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational winner pick: rotating priority from ptr when ARB_ROUND_ROBIN_EN is
// defined, otherwise fixed priority with port 0 highest (ptr ignored).
module rr_pick
   import noc_pkg::*;
(
   input  onehot5_t  req,
   input  port_idx_t ptr,
   output onehot5_t  win,
   output logic      valid
);

   assign valid = |req;

`ifdef ARB_ROUND_ROBIN_EN
   logic [2*N_PORTS-1:0] req_dbl;
   logic [2*N_PORTS-1:0] win_dbl;
   onehot5_t             rot;
   onehot5_t             rot_win;

   // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
   always_comb begin
      req_dbl = {req, req} >> ptr;
      rot     = req_dbl[N_PORTS-1:0];
      rot_win = rot & (~rot + 5'd1);
      win_dbl = {rot_win, rot_win} << ptr;
      win     = win_dbl[2*N_PORTS-1:N_PORTS];
   end
`else
   logic unused_ptr;

   assign unused_ptr = ^ptr;
   assign win        = req & (~req + 5'd1);
`endif

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port packet arbiter: registered one-hot grant held from head to tail.
// ARB_ROUND_ROBIN_EN selects rotating priority; default build is fixed priority.
module output_port_arbiter #(
   parameter int unsigned N_PORTS = 5,
   parameter int unsigned IDX_W   = 3
) (
   input logic                   clk,
   input logic                   rst,
   output_port_arbiter_if.master bus
);

   logic [N_PORTS-1:0]  req;
   logic [N_PORTS-1:0]  tail;
   noc_pkg::onehot5_t   win;
   logic                valid;
   logic                rel;
   noc_pkg::port_idx_t  pick_ptr;

   noc_pkg::arb_state_e state_d, state_q;
   logic [N_PORTS-1:0]  grant_d, grant_q;
   logic [IDX_W-1:0]    idx_d, idx_q;
   logic                busy_d, busy_q;

   assign req  = bus.req;
   assign tail = bus.tail;

   // Owner finishes on a tail transfer, or gives up by dropping its request.
   assign rel = (state_q == noc_pkg::StLocked) &&
                (!(|(req & grant_q)) || ((|(tail & grant_q)) && bus.out_ready));

`ifdef ARB_ROUND_ROBIN_EN
   noc_pkg::port_idx_t ptr_d, ptr_q, ptr_nxt;

   assign ptr_nxt  = noc_pkg::next_port(noc_pkg::port_idx_t'(idx_q));
   assign pick_ptr = rel ? ptr_nxt : ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (rel) ptr_d = ptr_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end
`else
   assign pick_ptr = '0;
`endif

   rr_pick u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .win   (win),
      .valid (valid)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      unique case (state_q)
         noc_pkg::StIdle: begin
            if (valid) begin
               grant_d = win;
               idx_d   = IDX_W'(noc_pkg::onehot_to_idx(win));
               busy_d  = 1'b1;
               state_d = noc_pkg::StLocked;
            end
         end
         noc_pkg::StLocked: begin
            if (rel) begin
               if (valid) begin
                  grant_d = win;
                  idx_d   = IDX_W'(noc_pkg::onehot_to_idx(win));
                  busy_d  = 1'b1;
               end else begin
                  grant_d = '0;
                  idx_d   = '0;
                  busy_d  = 1'b0;
                  state_d = noc_pkg::StIdle;
               end
            end
         end
         default: begin
            grant_d = '0;
            idx_d   = '0;
            busy_d  = 1'b0;
            state_d = noc_pkg::StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= noc_pkg::StIdle;
         grant_q <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.grant_idx = idx_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
module tb_output_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   output_port_arbiter_if #(.N_PORTS(5), .IDX_W(3)) bus ();

   output_port_arbiter #(.N_PORTS(5), .IDX_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4:0] g, input logic [2:0] idx);
      logic b;
      b = (g != 5'b0);
      n_cmp++;
      assert ({bus.grant, bus.grant_idx, bus.busy} === {g, idx, b}) else begin
         n_bad++;
         $error("FAIL %s: got grant=%b idx=%0d busy=%b, want grant=%b idx=%0d busy=%b",
                tag, bus.grant, bus.grant_idx, bus.busy, g, idx, b);
      end
   endtask

   logic [4:0] rr_g   [6] = '{5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
   logic [2:0] rr_idx [6] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      bus.req = '0;
      bus.tail = '0;
      bus.out_ready = 1'b0;
      #12;
      chk("reset", 5'b00000, 3'd0);
      rst = 1'b1;
      tick();
      chk("idle_no_req", 5'b00000, 3'd0);

      // 3-flit packet from port 1; requester drops req with the tail flit
      bus.req = 5'b00010;
      bus.out_ready = 1'b1;
      tick(); chk("single_f1", 5'b00010, 3'd1);
      tick(); chk("single_f2", 5'b00010, 3'd1);
      tick(); chk("single_f3", 5'b00010, 3'd1);
      bus.tail = 5'b00010;
      bus.req = 5'b00000;
      tick(); chk("single_done", 5'b00000, 3'd0);
      bus.tail = '0;

      // lock hold on port 2, other tails ignored, then backpressure on tail
      bus.req = 5'b00100;
      tick(); chk("lock_grant", 5'b00100, 3'd2);
      bus.req = 5'b11111;
      tick(); chk("lock_hold_req", 5'b00100, 3'd2);
      bus.tail = 5'b11011;
      tick(); chk("lock_other_tails", 5'b00100, 3'd2);
      bus.tail = 5'b00100;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(); chk("bp_hold", 5'b00100, 3'd2);
      end
      bus.out_ready = 1'b1;
      tick(); chk("bp_release", RR ? 5'b01000 : 5'b00001, RR ? 3'd3 : 3'd0);

      // all ports requesting single-flit packets
      bus.tail = 5'b11111;
      for (int i = 0; i < 6; i++) begin
         tick(); chk("fairness", RR ? rr_g[i] : 5'b00001, RR ? rr_idx[i] : 3'd0);
      end
      bus.req = '0;
      bus.tail = '0;
      tick(); chk("drain", 5'b00000, 3'd0);

      // abort: port 3 drops req mid-packet
      bus.req = 5'b01000;
      tick(); chk("abort_grant", 5'b01000, 3'd3);
      tick(); chk("abort_hold", 5'b01000, 3'd3);
      bus.req = 5'b00000;
      tick(); chk("abort_clear", 5'b00000, 3'd0);
      bus.req = 5'b10001;
      tick(); chk("abort_ptr", RR ? 5'b10000 : 5'b00001, RR ? 3'd4 : 3'd0);
      bus.req = '0;
      tick(); chk("idle_again", 5'b00000, 3'd0);

      // asynchronous reset mid-packet
      bus.req = 5'b00100;
      tick(); chk("rst_pre", 5'b00100, 3'd2);
      #2 rst = 1'b0;
      #1 chk("rst_async", 5'b00000, 3'd0);
      tick(); chk("rst_held", 5'b00000, 3'd0);
      rst = 1'b1;
      tick(); chk("rst_regrant", 5'b00100, 3'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

- Per-output-port switch arbiter for the 5-port router.
- Collects packet requests from the five input ports and issues a registered one-hot grant vector (the `g4x` grant lines).
- Holds each grant for a whole packet, head flit through tail flit.
- The downstream output-port selector turns this grant vector into crossbar select lines; this block is the grant-producing end of that interface.

## Interface

Parameters:
- `N_PORTS`, default 5: number of requesting input ports; the logic is written for 5.
- `IDX_W`, default 3: width of the encoded grant index.

Ports:
- `clk`, input, 1: single clock; all state is updated on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `req`, input, N_PORTS: `req[i]` means input port i has a packet waiting for this output port.
- `tail`, input, N_PORTS: `tail[i]` means the flit currently presented by port i is a tail flit.
- `out_ready`, input, 1: downstream has a credit, so a flit transfers this cycle.
- `grant`, output, N_PORTS: registered one-hot grant; all-zero when idle.
- `grant_idx`, output, IDX_W: binary index of the granted port; 0 when idle.
- `busy`, output, 1: high while a packet owns the output port.

## Operation

- **States:** IDLE and LOCKED.
- **Reset values:** `grant`=0, `grant_idx`=0, `busy`=0, priority pointer=0, state=IDLE.
- **IDLE:**
  - If `req`≠0, pick a winner starting at the pointer and going upward with wrap-around (see Configuration).
  - On that edge load `grant`, `grant_idx`, and `busy`=1, and go to LOCKED.
  - If `req`=0, stay in IDLE.
- **LOCKED with owner k:**
  - `grant` holds steady regardless of other requests.
  - A transfer happens in any cycle where `out_ready`=1.
- **Release at end of packet:** when `tail[k]` & `out_ready` & `req[k]` are all high in the same cycle:
  - The pointer becomes (k+1) mod 5.
  - If other requests are pending, arbitrate in the same cycle with the new pointer. The new grant appears on the next edge (back-to-back, no bubble), and the state stays LOCKED.
  - Otherwise return to IDLE with `grant`=0 and `busy`=0.
- **Abort:** if `req[k]` drops while LOCKED without a tail transfer, release on the next edge exactly as for a tail. The pointer still advances.
- **Ignored inputs:**
  - `tail[j]` for j≠k is ignored.
  - `tail[k]` with `out_ready`=0 does not release.
- **Single-flit packet:** the grant is issued on one edge. If head=tail and `out_ready`=1 on the following cycle, the grant lasts exactly one cycle.
- **Invariants:**
  - `grant` is always zero or one-hot.
  - `grant_idx` equals the encoded form of `grant`.
  - `busy` equals the OR of `grant` bits.

## Timing

- Request to grant: 1 cycle. `req` sampled high at edge t gives `grant` valid after edge t.
- Tail transfer to next grant: 1 cycle, with no idle cycle between packets.
- All outputs are registered directly from flops; there is no combinational path from input to output.
- Reset is asynchronous. Asserting it mid-packet clears `grant`, `busy`, and the pointer immediately, without waiting for a clock edge.
- Deassertion of `rst` is synchronised externally. The first arbitration happens on the first edge after release.

## Configuration

- Macro: `ARB_ROUND_ROBIN_EN`.
- **Defined:** rotating priority. The search starts at the pointer, and the pointer updates on every release as described above.
- **Undefined:** fixed priority, with port 0 highest and port 4 lowest. The pointer register is not built. Lock and release behaviour is unchanged.

## Structure

- **Shared package `noc_pkg`:**
  - `N_PORTS`.
  - Port index constants PORT_LOCAL/N/E/S/W = 0..4.
  - `onehot5_t` typedef.
  - The one-hot-to-index function (shared with the selectors).
- **Sub-module `rr_pick`:**
  - Purely combinational.
  - Inputs: `req` vector and pointer.
  - Outputs: one-hot winner and a valid flag.
  - Uses the fixed-priority form when `ARB_ROUND_ROBIN_EN` is not defined.
- **Top level:** contains the state register, pointer register, and release logic.

## Test plan

1. Reset behaviour: assert `rst` low mid-packet while `grant`=00100. `grant` becomes 0 and `busy` becomes 0 immediately. After release, `req`=00100 gives `grant`=00100 one cycle later.
2. Single request: `req`=00010 with `out_ready`=1 and a 3-flit packet.
   - `grant`=00010 for 3 cycles starting the cycle after the request.
   - Then `grant`=0 and `busy`=0.
3. Round-robin fairness: `req`=11111 held with single-flit packets.
   - Grants appear as 00001, 00010, 00100, 01000, 10000, 00001 on consecutive cycles.
   - Without the macro, the grant stays 00001 throughout.
4. Lock hold: port 2 is granted and `req` changes to 11111 mid-packet. `grant` stays 00100 until `tail[2]` & `out_ready`; the next grant is 01000.
5. Backpressure: `tail[2]`=1 with `out_ready`=0 for 4 cycles gives no release. Release happens on the first cycle `out_ready`=1.
6. Abort: `req[3]` drops mid-packet. `grant` clears on the next edge and the pointer moves to 4, so `req`=10001 is granted to port 4 next.
